// File: rtl/sdram_burst_sched.sv
// SDRAM burst scheduler: arbitrates write-FIFO drain vs read-FIFO refill,
// drives controller req/ack handshake and wrapping burst addresses.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   sdram_init_done            controller ready; gates arbitration
//   wrf_use, rdf_use           write / read FIFO fill levels
//   wr_load, rd_load           restart write / read address at base
//   sdram_wr_req/sdram_rd_req  registered burst requests
//   sdram_wr_ack/sdram_rd_ack  controller acks (burst ends on falling edge)
//   sys_wraddr, sys_rdaddr     current burst addresses
//   sdwr_byte, sdrd_byte       burst lengths (constant)
//   rd_wrap                    one-cycle pulse on read address wrap
//   busy                       high outside IDLE
module sdram_burst_sched #(
    parameter int          BURST   = 256,
    parameter logic [21:0] WR_BASE = 22'h000000,
    parameter logic [21:0] WR_END  = 22'h3FFFFF,
    parameter logic [21:0] RD_BASE = 22'h000000,
    parameter logic [21:0] RD_END  = 22'h3FFFFF,
    parameter int          RD_LOW  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [8:0]  wrf_use,
    input  logic [8:0]  rdf_use,
    input  logic        wr_load,
    input  logic        rd_load,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    output logic [21:0] sys_wraddr,
    output logic [21:0] sys_rdaddr,
    output logic [8:0]  sdwr_byte,
    output logic [8:0]  sdrd_byte,
    output logic        rd_wrap,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, WREQ, WBURST, RREQ, RBURST, GAP
    } state_t;

    localparam logic [9:0]  ROOM   = 10'(512 - BURST);
    localparam logic [9:0]  LOW    = 10'(RD_LOW);
    localparam logic [9:0]  FULL   = 10'(BURST);
    localparam logic [22:0] STEP   = 23'(BURST);
    localparam logic [22:0] WR_LIM = {1'b0, WR_END} - STEP + 23'd1;
    localparam logic [22:0] RD_LIM = {1'b0, RD_END} - STEP + 23'd1;

    state_t state, state_nx;

    logic        wr_ack_d, rd_ack_d;
    logic        wr_pend, rd_pend;
    logic        wr_fall, rd_fall;
    logic        wr_adv, rd_adv;
    logic        wr_in_burst, rd_in_burst;
    logic        rd_room, rd_urgent, wr_full;
    logic [22:0] wr_sum, rd_sum;
    logic        wr_wrap_c, rd_wrap_c;

    assign sdwr_byte = 9'(BURST);
    assign sdrd_byte = 9'(BURST);

    assign rd_room   = {1'b0, rdf_use} <= ROOM;
    assign rd_urgent = ({1'b0, rdf_use} < LOW) && rd_room;
    assign wr_full   = {1'b0, wrf_use} >= FULL;

    assign wr_fall = wr_ack_d & ~sdram_wr_ack;
    assign rd_fall = rd_ack_d & ~sdram_rd_ack;
    assign wr_adv  = (state == WBURST) && wr_fall;
    assign rd_adv  = (state == RBURST) && rd_fall;

    assign wr_in_burst = (state == WREQ) || (state == WBURST);
    assign rd_in_burst = (state == RREQ) || (state == RBURST);

    // 23-bit sums so a 22-bit overflow is visible as bit 22
    assign wr_sum    = {1'b0, sys_wraddr} + STEP;
    assign rd_sum    = {1'b0, sys_rdaddr} + STEP;
    assign wr_wrap_c = wr_sum[22] || (wr_sum > WR_LIM);
    assign rd_wrap_c = rd_sum[22] || (rd_sum > RD_LIM);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sdram_init_done) begin
                    if (rd_urgent)    state_nx = RREQ;
                    else if (wr_full) state_nx = WREQ;
                    else if (rd_room) state_nx = RREQ;
                end
            end
            WREQ:    if (sdram_wr_ack) state_nx = WBURST;
            WBURST:  if (wr_fall)      state_nx = GAP;
            RREQ:    if (sdram_rd_ack) state_nx = RBURST;
            RBURST:  if (rd_fall)      state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            busy         <= 1'b0;
            rd_wrap      <= 1'b0;
            wr_ack_d     <= 1'b0;
            rd_ack_d     <= 1'b0;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
            sys_wraddr   <= WR_BASE;
            sys_rdaddr   <= RD_BASE;
        end else begin
            state        <= state_nx;
            sdram_wr_req <= (state_nx == WREQ);
            sdram_rd_req <= (state_nx == RREQ);
            busy         <= (state_nx != IDLE);
            wr_ack_d     <= sdram_wr_ack;
            rd_ack_d     <= sdram_rd_ack;
            rd_wrap      <= 1'b0;

            // a load seen during its own burst is deferred to burst end
            if (wr_adv) begin
                wr_pend <= 1'b0;
                if (wr_pend || wr_load || wr_wrap_c)
                    sys_wraddr <= WR_BASE;
                else
                    sys_wraddr <= wr_sum[21:0];
            end else if (wr_load) begin
                if (wr_in_burst) wr_pend    <= 1'b1;
                else             sys_wraddr <= WR_BASE;
            end

            if (rd_adv) begin
                rd_pend <= 1'b0;
                if (rd_pend || rd_load) begin
                    sys_rdaddr <= RD_BASE;
                end else if (rd_wrap_c) begin
                    sys_rdaddr <= RD_BASE;
                    rd_wrap    <= 1'b1;
                end else begin
                    sys_rdaddr <= rd_sum[21:0];
                end
            end else if (rd_load) begin
                if (rd_in_burst) rd_pend    <= 1'b1;
                else             sys_rdaddr <= RD_BASE;
            end
        end
    end

endmodule

// File: doc/sdram_burst_sched.md
# sdram_burst_sched

Burst scheduler that sits between the write FIFO (flash loader side), the read FIFO (LCD side) and the SDRAM controller top. It watches both FIFO fill levels, decides which direction to serve, and drives the controller's request/ack handshake. It also generates auto-incrementing, wrapping burst addresses and fixed burst lengths, so the LCD read stream never underflows while flash data is written into the frame buffer.

## Interface
Parameters:
- BURST, 256: words per burst; power of two, 1..256, so a burst never crosses a row.
- WR_BASE, 22'h000000: first write address (bank[21:20], row[19:8], col[7:0]).
- WR_END, 22'h3FFFFF: last valid write address, inclusive.
- RD_BASE, 22'h000000: first read address.
- RD_END, 22'h3FFFFF: last valid read address, inclusive.
- RD_LOW, 128: a read is urgent when read-FIFO fill is below this value.

Ports:
- clk  in  1  system clock, 100 MHz; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- sdram_init_done  in  1  SDRAM initialisation complete.
- wrf_use  in  9  words currently held in the write FIFO.
- rdf_use  in  9  words currently held in the read FIFO.
- wr_load  in  1  pulse that restarts the write address at WR_BASE.
- rd_load  in  1  pulse that restarts the read address at RD_BASE (frame start).
- sdram_wr_req  out  1  write request to the controller.
- sdram_rd_req  out  1  read request to the controller.
- sdram_wr_ack  in  1  high while write data is consumed; drives write-FIFO read enable.
- sdram_rd_ack  in  1  high while read data is valid.
- sys_wraddr  out  22  current write burst address.
- sys_rdaddr  out  22  current read burst address.
- sdwr_byte  out  9  write burst length; constant BURST.
- sdrd_byte  out  9  read burst length; constant BURST.
- rd_wrap  out  1  one-cycle pulse when the read address wraps to RD_BASE.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WREQ, WBURST, RREQ, RBURST, GAP.
- IDLE: arbitration runs only when sdram_init_done=1.
  - Priority 1: rdf_use < RD_LOW and rdf_use <= 512-BURST → RREQ.
  - Else priority 2: wrf_use >= BURST → WREQ.
  - Else priority 3: rdf_use <= 512-BURST (read prefetch) → RREQ.
  - Otherwise stay in IDLE.
- WREQ: sdram_wr_req=1 until the cycle sdram_wr_ack is seen high → WBURST. The request drops in the cycle after ack rises.
- WBURST: wait for the falling edge of sdram_wr_ack (ack was 1, now 0), then advance the write address → GAP.
- RREQ/RBURST: same sequence using sdram_rd_req and sdram_rd_ack.
- GAP: one cycle so FIFO counts can settle → IDLE.
- Address advance: next = addr + BURST. If next > END - BURST + 1, or next overflows 22 bits, the address becomes BASE. A read wrap pulses rd_wrap.
- wr_load/rd_load:
  - In IDLE or GAP: the address is set to BASE on the next cycle.
  - During a burst of the same direction: the load is latched in a pending flag and applied instead of the normal advance at burst end.
  - A load and an advance in the same cycle: the load wins.
- A burst, once requested, always completes. There is no abort.
- sdram_init_done dropping mid-burst has no effect until the block returns to IDLE.

## Timing
- Reset values:
  - sdram_wr_req=0, sdram_rd_req=0, rd_wrap=0, busy=0.
  - sys_wraddr=WR_BASE, sys_rdaddr=RD_BASE.
  - sdwr_byte=sdrd_byte=BURST.
  - State is IDLE and pending-load flags are clear.
- All outputs are registered.
- Request latency: the request rises 1 cycle after the IDLE decision cycle.
- Address update: the address is valid in the cycle GAP is entered. The address is stable from request assertion until the ack falling edge.
- Only one of sdram_wr_req/sdram_rd_req is ever high; the other stays 0.
- Minimum spacing: 2 idle cycles between an ack falling edge and the next request (GAP plus IDLE).
- An ack arriving without a request is ignored in IDLE.

## Test plan
- Reset, init_done=1, wrf_use=256, rdf_use=300 → sdram_wr_req rises 2 cycles later, sys_wraddr=WR_BASE. After a 256-cycle ack, sys_wraddr=0x000100.
- rdf_use=50 and wrf_use=256 in the same cycle → sdram_rd_req asserted first and sdram_wr_req stays 0. After the read burst completes, with rdf_use=306, a write burst follows.
- RD_END=22'h0003FF, four read bursts → addresses 0x000, 0x100, 0x200, 0x300, then 0x000 with a rd_wrap pulse of exactly 1 cycle.
- rd_load pulsed mid read burst at address 0x200 → the burst completes and the next sys_rdaddr=RD_BASE, not 0x300.
- init_done=0 with both FIFOs requesting → no request for 1000 cycles. Raise init_done → a request appears within 2 cycles.
- rst_n asserted during WBURST → all outputs return to reset values asynchronously. After release, the first request is re-arbitrated from IDLE.
